endec_scheduler: RTL and testbench
==================================

ENDEC_SCHEDULER -- requirements
Module: endec_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, watchdog limit in cycles without core progress; legal range 2..65535.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_req  input  2  per-requester job request; requester r holds i_req[r] high until o_done[r].
REQ-005 i_req_mode  input  2  per-requester mode: 0 encode, 1 decode.
REQ-006 i_req_code_rate  input  2  per-requester code rate select.
REQ-007 i_req_constr_len  input  4  per-requester constraint length select, 2 bits each, requester r at [2r+1:2r].
REQ-008 i_req_len  input  16  per-requester encode length in bits, 8 bits each at [8r+7:8r]; ignored in decode.
REQ-009 o_gnt  output  2  one-hot grant, high from CLEAR through DONE of the owning job.
REQ-010 o_done  output  2  one-hot, one-cycle job-complete pulse.
REQ-011 o_err  output  1  valid with o_done; 1 = job aborted by watchdog.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_core_rst  output  1  one-cycle datapath clear pulse.
REQ-014 o_core_en  output  1  datapath enable, high only in RUN.
REQ-015 o_core_mode_sel, o_core_code_rate  output  1 each  latched job mode and code rate.
REQ-016 o_core_constr_len  output  2  latched constraint length.
REQ-017 i_core_enc_done  input  1  encoder one-bit-done pulse.
REQ-018 i_core_dec_done  input  1  decoder frame-done pulse.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, DONE.
REQ-020 IDLE: if any i_req is high, arbitrate, latch the winner's descriptor, go to CLEAR next cycle.
REQ-021 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the pointer updates on grant.
REQ-022 CLEAR: o_core_rst=1 for exactly one cycle, o_core_en=0; next state RUN, or DONE if encode with len=0 (o_err=0).
REQ-023 RUN: o_core_en=1; encode counts i_core_enc_done pulses, leaving for DONE on the cycle the count reaches len; decode leaves for DONE on the first i_core_dec_done.
REQ-024 Done pulses of the non-selected mode SHALL be ignored in RUN; all core done inputs are ignored outside RUN.
REQ-025 Watchdog SHALL clear on entering RUN and on every counted done pulse, increment otherwise in RUN, and force DONE with o_err=1 when it reaches TIMEOUT_CYCLES.
REQ-026 If completion and watchdog expiry occur in the same cycle, completion wins (o_err=0).
REQ-027 DONE: o_done[granted]=1 and o_err valid for one cycle, o_core_en=0; next state IDLE; o_gnt drops on exit.
REQ-028 Latency: i_req rising in IDLE at cycle t -> o_gnt and o_core_rst at t+1, o_core_en at t+2; o_done one cycle after the completing event; next grant no earlier than the cycle after DONE.
REQ-029 Descriptor latched at grant; i_req or descriptor changes during a job SHALL not affect it; i_req dropped mid-job does not abort.
REQ-030 Core config outputs hold the last job's values in IDLE.
REQ-031 Encode bit counter width 8; len=255 SHALL complete after 255 pulses without wrap.

Reset
REQ-032 On rst: state IDLE, every output 0, RR pointer favours requester 0, counters and watchdog 0.
REQ-033 rst mid-job SHALL abort without o_done; no pending state survives.

Structure
REQ-034 Shared package holds the FSM state enum, mode encoding (ENC=0, DEC=1) and TIMEOUT_CYCLES default.
REQ-035 One sub-module: rr_arbiter2 (2-way round-robin, one-hot grant, pointer update on accept).

Verification
REQ-036 Req0 encode len=4, four enc_done pulses 3 cycles apart -> o_core_en high from t+2, o_done=01 one cycle after 4th pulse, o_err=0.
REQ-037 Both requesters decode, held simultaneously from reset -> grants 01 then 10, each ending after its dec_done; next rerequest of 0 wins.
REQ-038 Decode job, no dec_done, TIMEOUT_CYCLES=16 -> DONE 16 cycles into RUN, o_err=1, o_core_en low.
REQ-039 Encode len=0 -> CLEAR then DONE, o_core_en never high, o_err=0.
REQ-040 rst asserted in RUN with 2 of 4 bits done -> next cycle all outputs 0, no o_done; new request starts cleanly.
REQ-041 Decode job with stray enc_done pulses and dec_done coincident with watchdog expiry -> enc pulses ignored, o_err=0.

Source files
------------

// File: rtl/endec_scheduler_pkg.sv
// Shared types and constants for the encoder/decoder job scheduler.
package endec_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

endpackage

// File: rtl/endec_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, priority pointer moves on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio;  // 0: requester 0 favoured on a tie, 1: requester 1 favoured

  always_comb begin
    // NOTE: default first so no path leaves gnt unassigned, which would infer a latch.
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/endec_scheduler.sv
// Schedules encode/decode jobs from two requesters onto one shared core with a progress watchdog.
module endec_scheduler
  import endec_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_req_mode,
  input  logic [1:0]  i_req_code_rate,
  input  logic [3:0]  i_req_constr_len,
  input  logic [15:0] i_req_len,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_core_rst,
  output logic        o_core_en,
  output logic        o_core_mode_sel,
  output logic        o_core_code_rate,
  output logic [1:0]  o_core_constr_len,
  input  logic        i_core_enc_done,
  input  logic        i_core_dec_done
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  arb_gnt;
  logic        sel;
  logic [7:0]  job_len;
  logic [7:0]  bit_cnt;
  logic [15:0] wdog;
  logic        enc_hit;
  logic        dec_hit;
  logic        enc_last;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (i_req),
    .accept (state == IDLE),
    .gnt    (arb_gnt)
  );

  assign sel      = arb_gnt[1];
  // Done pulses only count when they match the latched job mode.
  assign enc_hit  = i_core_enc_done && (o_core_mode_sel == MODE_ENC);
  assign dec_hit  = i_core_dec_done && (o_core_mode_sel == MODE_DEC);
  assign enc_last = enc_hit && ((bit_cnt + 8'd1) == job_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      o_gnt             <= 2'b00;
      o_done            <= 2'b00;
      o_err             <= 1'b0;
      o_busy            <= 1'b0;
      o_core_rst        <= 1'b0;
      o_core_en         <= 1'b0;
      o_core_mode_sel   <= 1'b0;
      o_core_code_rate  <= 1'b0;
      o_core_constr_len <= 2'b00;
      job_len           <= 8'd0;
      bit_cnt           <= 8'd0;
      wdog              <= 16'd0;
    end else begin
      // NOTE: non-blocking updates, so every branch below sees pre-edge values.
      o_done     <= 2'b00;
      o_err      <= 1'b0;
      o_core_rst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req != 2'b00) begin
            state             <= CLEAR;
            o_gnt             <= arb_gnt;
            o_busy            <= 1'b1;
            o_core_rst        <= 1'b1;
            o_core_mode_sel   <= i_req_mode[sel];
            o_core_code_rate  <= i_req_code_rate[sel];
            o_core_constr_len <= i_req_constr_len[{sel, 1'b0} +: 2];
            job_len           <= i_req_len[{sel, 3'b000} +: 8];
          end
        end
        CLEAR: begin
          bit_cnt <= 8'd0;
          wdog    <= 16'd0;
          if ((o_core_mode_sel == MODE_ENC) && (job_len == 8'd0)) begin
            state  <= DONE;
            o_done <= o_gnt;
          end else begin
            state     <= RUN;
            o_core_en <= 1'b1;
          end
        end
        RUN: begin
          // Completion is tested before the watchdog so a coincident finish is not an error.
          if (enc_last || dec_hit) begin
            state     <= DONE;
            o_done    <= o_gnt;
            o_core_en <= 1'b0;
          end else if (enc_hit) begin
            bit_cnt <= bit_cnt + 8'd1;
            wdog    <= 16'd0;
          end else if (wdog == WDOG_LAST) begin
            state     <= DONE;
            o_done    <= o_gnt;
            o_err     <= 1'b1;
            o_core_en <= 1'b0;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_gnt  <= 2'b00;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_endec_scheduler.sv
// Randomized self-checking bench for endec_scheduler against a gap-based job-completion model.
module tb_endec_scheduler;
  import endec_scheduler_pkg::*;

  localparam int T       = 16;
  localparam int SCHED_N = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_req;
  logic [1:0]  i_req_mode;
  logic [1:0]  i_req_code_rate;
  logic [3:0]  i_req_constr_len;
  logic [15:0] i_req_len;
  logic [1:0]  o_gnt;
  logic [1:0]  o_done;
  logic        o_err;
  logic        o_busy;
  logic        o_core_rst;
  logic        o_core_en;
  logic        o_core_mode_sel;
  logic        o_core_code_rate;
  logic [1:0]  o_core_constr_len;
  logic        i_core_enc_done;
  logic        i_core_dec_done;

  always #5 clk = ~clk;

  endec_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_req             (i_req),
    .i_req_mode        (i_req_mode),
    .i_req_code_rate   (i_req_code_rate),
    .i_req_constr_len  (i_req_constr_len),
    .i_req_len         (i_req_len),
    .o_gnt             (o_gnt),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_busy            (o_busy),
    .o_core_rst        (o_core_rst),
    .o_core_en         (o_core_en),
    .o_core_mode_sel   (o_core_mode_sel),
    .o_core_code_rate  (o_core_code_rate),
    .o_core_constr_len (o_core_constr_len),
    .i_core_enc_done   (i_core_enc_done),
    .i_core_dec_done   (i_core_dec_done)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  logic enc_sched [SCHED_N];
  logic dec_sched [SCHED_N];
  int   exp_d;    // RUN-relative cycle index at which o_done is expected
  logic exp_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] all_outs();
    return {o_gnt, o_done, o_err, o_busy, o_core_rst, o_core_en,
            o_core_mode_sel, o_core_code_rate, o_core_constr_len};
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < SCHED_N; k++) begin
      enc_sched[k] = 1'b0;
      dec_sched[k] = 1'b0;
    end
  endtask

  // Encode model: each bit arrives g idle cycles after the last watchdog clear; g >= T expires first.
  task automatic plan_enc(input int len, input int max_gap, input int to_odds);
    int c, g, p;
    clear_sched();
    c = 0; exp_d = 0; exp_err = 1'b0;
    for (int i = 1; i <= len; i++) begin
      g = (to_odds > 0 && $urandom_range(to_odds - 1, 0) == 0) ? T : int'($urandom_range(max_gap, 0));
      if (g >= T) begin
        exp_d = c + T; exp_err = 1'b1;
        break;
      end
      p = c + g;
      enc_sched[p] = 1'b1;
      c = p + 1;
      if (i == len) exp_d = p + 1;
    end
    for (int k = 0; k < exp_d; k++)
      if ($urandom_range(3, 0) == 0) dec_sched[k] = 1'b1;
  endtask

  // Decode model: frame done at RUN cycle q finishes if q < T, otherwise the watchdog fires after T cycles.
  task automatic plan_dec(input int q, input int stray_odds);
    clear_sched();
    if (q < T) begin
      exp_d = q + 1; exp_err = 1'b0;
    end else begin
      exp_d = T; exp_err = 1'b1;
    end
    if (q < SCHED_N) dec_sched[q] = 1'b1;
    for (int k = 0; k < exp_d; k++)
      if ($urandom_range(stray_odds - 1, 0) == 0) enc_sched[k] = 1'b1;
  endtask

  task automatic run_job(input int r, input logic mode, input logic cr, input logic [1:0] cl,
                         input logic [7:0] len, input bit scramble);
    logic [1:0] oh, done_val;
    logic       err_val;
    int         done_at, en_cnt;
    oh = (r == 0) ? 2'b01 : 2'b10;
    i_req_mode[r]              = mode;
    i_req_code_rate[r]         = cr;
    i_req_constr_len[2*r +: 2] = cl;
    i_req_len[8*r +: 8]        = len;
    i_req[r]                   = 1'b1;
    tick();
    vectors++;
    if ({o_gnt, o_core_rst, o_core_en, o_busy} !== {oh, 3'b101}) begin
      miscompares++;
      $display("FAIL grant_cycle: got gnt/rst/en/busy %b expected %b", {o_gnt, o_core_rst, o_core_en, o_busy}, {oh, 3'b101});
    end
    vectors++;
    if ({o_core_mode_sel, o_core_code_rate, o_core_constr_len} !== {mode, cr, cl}) begin
      miscompares++;
      $display("FAIL latched_cfg: got %b expected %b", {o_core_mode_sel, o_core_code_rate, o_core_constr_len}, {mode, cr, cl});
    end
    if (scramble) begin
      i_req_mode       = 2'($urandom);
      i_req_code_rate  = 2'($urandom);
      i_req_constr_len = 4'($urandom);
      i_req_len        = 16'($urandom);
    end
    done_at = -1; done_val = 2'b00; err_val = 1'bx; en_cnt = 0;
    for (int k = 0; k <= exp_d + 2; k++) begin
      tick();
      if (k == 0) begin
        vectors++;
        if (o_core_rst !== 1'b0) begin
          miscompares++;
          $display("FAIL core_rst_width: got %b expected 0", o_core_rst);
        end
      end
      if (o_core_en === 1'b1) en_cnt++;
      if (o_done !== 2'b00) begin
        done_at = k; done_val = o_done; err_val = o_err;
        break;
      end
      i_core_enc_done = enc_sched[k];
      i_core_dec_done = dec_sched[k];
    end
    i_core_enc_done = 1'b0;
    i_core_dec_done = 1'b0;
    i_req           = 2'b00;
    vectors++;
    if (done_at != exp_d) begin
      miscompares++;
      $display("FAIL done_time: got %0d expected %0d", done_at, exp_d);
    end
    vectors++;
    if ({done_val, err_val} !== {oh, exp_err}) begin
      miscompares++;
      $display("FAIL done_err: got %b expected %b", {done_val, err_val}, {oh, exp_err});
    end
    vectors++;
    if (en_cnt != exp_d) begin
      miscompares++;
      $display("FAIL core_en_cycles: got %0d expected %0d", en_cnt, exp_d);
    end
    tick();
    vectors++;
    if ({o_gnt, o_done, o_busy, o_core_en, o_core_mode_sel, o_core_code_rate, o_core_constr_len} !==
        {6'b000000, mode, cr, cl}) begin
      miscompares++;
      $display("FAIL idle_after_job: got %b expected %b",
               {o_gnt, o_done, o_busy, o_core_en, o_core_mode_sel, o_core_code_rate, o_core_constr_len},
               {6'b000000, mode, cr, cl});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 2'b11;
    i_req_mode = 2'b11;
    i_req_code_rate = 2'($urandom);
    i_req_constr_len = 4'($urandom);
    i_req_len = 16'($urandom);
    i_core_enc_done = 1'b1;
    i_core_dec_done = 1'b1;
    tick();
    tick();
    i_core_enc_done = 1'b0;
    i_core_dec_done = 1'b0;
    vectors++;
    if (all_outs() !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero", all_outs());
    end
  endtask

  // Both requesters decode, held from reset.
  task automatic test_round_robin();
    rst = 1'b0;
    tick();
    vectors++;
    if (o_gnt !== 2'b01) begin
      miscompares++; $display("FAIL rr_first: got %b expected 01", o_gnt);
    end
    tick();
    i_core_dec_done = 1'b1;
    tick();
    vectors++;
    if ({o_done, o_err} !== 3'b010) begin
      miscompares++; $display("FAIL rr_first_done: got %b expected 010", {o_done, o_err});
    end
    i_core_dec_done = 1'b0;
    i_req[0] = 1'b0;
    tick();
    i_req[0] = 1'b1;
    tick();
    vectors++;
    if (o_gnt !== 2'b10) begin
      miscompares++; $display("FAIL rr_second: got %b expected 10", o_gnt);
    end
    tick();
    i_core_dec_done = 1'b1;
    tick();
    vectors++;
    if ({o_done, o_err} !== 3'b100) begin
      miscompares++; $display("FAIL rr_second_done: got %b expected 100", {o_done, o_err});
    end
    i_core_dec_done = 1'b0;
    i_req[1] = 1'b0;
    tick();
    i_req[1] = 1'b1;
    tick();
    vectors++;
    if (o_gnt !== 2'b01) begin
      miscompares++; $display("FAIL rr_rerequest: got %b expected 01", o_gnt);
    end
    rst = 1'b1;
    i_req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_encode_basic();
    clear_sched();
    enc_sched[2] = 1'b1; enc_sched[5] = 1'b1; enc_sched[8] = 1'b1; enc_sched[11] = 1'b1;
    exp_d = 12; exp_err = 1'b0;
    run_job(0, MODE_ENC, 1'b1, 2'b10, 8'd4, 1'b0);
  endtask

  task automatic test_len_zero();
    plan_enc(0, 0, 0);
    run_job(1, MODE_ENC, 1'b0, 2'b01, 8'd0, 1'b0);
  endtask

  task automatic test_timeout();
    plan_dec(T + 10, 1000);
    run_job(0, MODE_DEC, 1'b0, 2'b11, 8'd7, 1'b0);
  endtask

  task automatic test_coincident();
    plan_dec(T - 1, 2);
    run_job(1, MODE_DEC, 1'b1, 2'b00, 8'd3, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    i_req_mode[0] = MODE_ENC;
    i_req_len[7:0] = 8'd4;
    i_req[0] = 1'b1;
    tick();
    tick();
    i_core_enc_done = 1'b1;
    tick();
    tick();
    i_core_enc_done = 1'b0;
    rst = 1'b1;
    vectors++;
    if ({o_done, o_core_en} !== 3'b001) begin
      miscompares++; $display("FAIL mid_job_before_rst: got %b expected 001", {o_done, o_core_en});
    end
    tick();
    vectors++;
    if (all_outs() !== 12'd0) begin
      miscompares++; $display("FAIL mid_job_reset: got %b expected all zero", all_outs());
    end
    rst = 1'b0;
    i_req = 2'b00;
    tick();
    clear_sched();
    for (int k = 0; k < 4; k++) enc_sched[k] = 1'b1;
    exp_d = 4; exp_err = 1'b0;
    run_job(0, MODE_ENC, 1'b0, 2'b01, 8'd4, 1'b0);
  endtask

  task automatic test_len255();
    plan_enc(255, T - 1, 0);
    run_job(1, MODE_ENC, 1'b1, 2'b11, 8'd255, 1'b1);
  endtask

  task automatic test_random_jobs();
    for (int n = 0; n < 40; n++) begin
      int         r;
      logic       mode, cr;
      logic [1:0] cl;
      logic [7:0] len;
      r    = int'($urandom_range(1, 0));
      mode = 1'($urandom);
      cr   = 1'($urandom);
      cl   = 2'($urandom);
      len  = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(24, 1));
      if (mode == MODE_ENC) plan_enc(int'(len), T - 1, 40);
      else                  plan_dec(int'($urandom_range(T + 2, 0)), 3);
      run_job(r, mode, cr, cl, len, 1'b1);
      repeat ($urandom_range(2, 0)) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    i_req = 2'b00;
    i_req_mode = 2'b00;
    i_req_code_rate = 2'b00;
    i_req_constr_len = 4'd0;
    i_req_len = 16'd0;
    i_core_enc_done = 1'b0;
    i_core_dec_done = 1'b0;
    test_reset();
    test_round_robin();
    test_encode_basic();
    test_len_zero();
    test_timeout();
    test_coincident();
    test_reset_mid_job();
    test_len255();
    test_random_jobs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
